// File: rtl/verify_sequencer.sv
// verify_sequencer: steps a digit index across the reference code and the
// user-entry buffer, compares one digit per cycle, reports a pass/fail result,
// tracks remaining attempts and enforces a timed lockout after repeated failures.
module verify_sequencer #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int unsigned TRY_W      = $clog2(MAX_TRIES + 1),
    localparam int unsigned LOCK_W     = $clog2(LOCK_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DIGIT_W-1:0] entry_digit,
    input  logic [DIGIT_W-1:0] ref_digit,
    output logic [IDX_W-1:0]   idx,
    output logic               busy,
    output logic               analysis_done,
    output logic               match,
    output logic               locked,
    output logic [TRY_W-1:0]   tries_left
);

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StResult,
        StLockout
    } state_e;

    localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N_DIGITS - 1);
    localparam logic [TRY_W-1:0]  FullTry  = TRY_W'(MAX_TRIES);
    localparam logic [LOCK_W-1:0] LockLoad = LOCK_W'(LOCK_CYCLES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mismatch_q, mismatch_d;
    logic               match_q, match_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        match_d    = match_q;
        tries_d    = tries_q;
        lock_cnt_d = lock_cnt_q;

        unique case (state_q)
            StIdle: begin
                // abort wins over start when both are raised together
                if (start && !abort) begin
                    state_d    = StCompare;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end
            end
            StCompare: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    mismatch_d = mismatch_q | (entry_digit != ref_digit);
                    if (idx_q == LastIdx) begin
                        state_d = StResult;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StResult: begin
                match_d = ~mismatch_q;
                if (!mismatch_q) begin
                    tries_d = FullTry;
                    state_d = StIdle;
                end else begin
                    if (tries_q != '0) begin
                        tries_d = tries_q - TRY_W'(1);
                    end
                    // last remaining try just consumed
                    if (tries_q <= TRY_W'(1)) begin
                        state_d    = StLockout;
                        lock_cnt_d = LockLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLockout: begin
                if (lock_cnt_q != '0) begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
                if (lock_cnt_q <= LOCK_W'(1)) begin
                    state_d = StIdle;
                    tries_d = FullTry;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            match_q    <= 1'b0;
            tries_q    <= FullTry;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            match_q    <= match_d;
            tries_q    <= tries_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign idx           = idx_q;
    assign match         = match_q;
    assign tries_left    = tries_q;
    assign busy          = (state_q == StCompare) || (state_q == StResult);
    assign analysis_done = (state_q == StResult);
    assign locked        = (state_q == StLockout);

endmodule

// File: tb/tb_verify_sequencer.sv
// Self-checking bench for verify_sequencer: directed scenarios plus randomized
// attempts, all checked against a code-level model of tries, match and lockout.
module tb_verify_sequencer;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int MT    = 3;
    localparam int LC    = 16;
    localparam int IDX_W = 2;
    localparam int TRY_W = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [DW-1:0]     em [N];
    logic [DW-1:0]     rm [N];
    logic [DW-1:0]     entry_digit;
    logic [DW-1:0]     ref_digit;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic              analysis_done;
    logic              match;
    logic              locked;
    logic [TRY_W-1:0]  tries_left;

    int errors = 0;
    int checks = 0;
    int tries_m;
    bit match_m;

    verify_sequencer #(
        .N_DIGITS    (N),
        .DIGIT_W     (DW),
        .MAX_TRIES   (MT),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .entry_digit   (entry_digit),
        .ref_digit     (ref_digit),
        .idx           (idx),
        .busy          (busy),
        .analysis_done (analysis_done),
        .match         (match),
        .locked        (locked),
        .tries_left    (tries_left)
    );

    // Digit stores are combinational reads at idx.
    assign entry_digit = em[idx];
    assign ref_digit   = rm[idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // The code matches only when every entry digit equals its reference digit.
    function automatic bit model_pass();
        for (int i = 0; i < N; i++) begin
            if (em[i] !== rm[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_codes(input int e0, e1, e2, e3, input int r0, r1, r2, r3);
        em[0] = DW'(e0); em[1] = DW'(e1); em[2] = DW'(e2); em[3] = DW'(e3);
        rm[0] = DW'(r0); rm[1] = DW'(r1); rm[2] = DW'(r2); rm[3] = DW'(r3);
    endtask

    // Pulse start and follow the compare until analysis_done; stimulus only.
    // lat counts clock edges from the one that samples start, -1 on timeout.
    task automatic launch_and_wait(output int lat, output bit idx_ok);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        idx_ok = 1'b1;
        lat = -1;
        for (int k = 0; k < N + 8; k++) begin
            if (analysis_done === 1'b1) begin
                lat = k + 1;
                break;
            end
            if (idx !== IDX_W'(k) || busy !== 1'b1) idx_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    // One full attempt with the current codes, including any lockout it causes.
    task automatic run_attempt(input string name);
        int lat;
        bit ok;
        bit pass;
        bit lock;
        bit bad;
        int cnt;
        pass = model_pass();
        launch_and_wait(lat, ok);
        checks++;
        if (lat != N + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, lat, N + 1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s idx_seq: idx/busy did not step 0..%0d", name, N - 1);
        end
        match_m = pass;
        lock = 1'b0;
        if (pass) begin
            tries_m = MT;
        end else begin
            if (tries_m > 0) tries_m--;
            if (tries_m == 0) lock = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (match !== match_m) begin
            errors++;
            $display("FAIL %s match: got %b, want %b", name, match, match_m);
        end
        checks++;
        if (tries_left !== TRY_W'(tries_m)) begin
            errors++;
            $display("FAIL %s tries_left: got %0d, want %0d", name, tries_left, tries_m);
        end
        checks++;
        if (analysis_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: analysis_done=%b after RESULT, want 0", name,
                     analysis_done);
        end
        checks++;
        if (locked !== lock) begin
            errors++;
            $display("FAIL %s locked: got %b, want %b", name, locked, lock);
        end
        if (lock) begin
            cnt = 0;
            bad = 1'b0;
            while (locked === 1'b1 && cnt < LC + 8) begin
                if (cnt == 3) start = 1'b1;
                if (cnt == 6) start = 1'b0;
                if (busy !== 1'b0) bad = 1'b1;
                cnt++;
                @(negedge clk);
            end
            start = 1'b0;
            checks++;
            if (cnt != LC) begin
                errors++;
                $display("FAIL %s lock_len: locked for %0d cycles, want %0d", name, cnt, LC);
            end
            checks++;
            if (bad || busy !== 1'b0 || idx !== '0) begin
                errors++;
                $display("FAIL %s lock_ignore: busy=%b idx=%0d, want idle (start ignored)",
                         name, busy, idx);
            end
            tries_m = MT;
            checks++;
            if (tries_left !== TRY_W'(tries_m)) begin
                errors++;
                $display("FAIL %s lock_exit_tries: got %0d, want %0d", name, tries_left,
                         tries_m);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_codes(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #10;
        checks++;
        if (idx !== '0 || busy !== 1'b0 || analysis_done !== 1'b0 || match !== 1'b0 ||
            locked !== 1'b0 || tries_left !== TRY_W'(MT)) begin
            errors++;
            $display("FAIL reset_values: idx=%0d busy=%b done=%b match=%b locked=%b tries=%0d",
                     idx, busy, analysis_done, match, locked, tries_left);
        end
        @(negedge clk);
        rst = 1'b1;
        tries_m = MT;
        match_m = 1'b0;
    endtask

    task automatic test_pass();
        set_codes(1, 2, 3, 4, 1, 2, 3, 4);
        run_attempt("pass");
    endtask

    task automatic test_fail();
        set_codes(1, 2, 3, 5, 1, 2, 3, 4);
        run_attempt("fail_last");
        set_codes(9, 2, 3, 4, 1, 2, 3, 4);
        run_attempt("fail_first");
        set_codes(1, 2, 3, 4, 1, 2, 3, 4);
        run_attempt("fail_then_pass");
    endtask

    task automatic test_lockout();
        set_codes(1, 2, 3, 5, 1, 2, 3, 4);
        run_attempt("lock_fail1");
        run_attempt("lock_fail2");
        run_attempt("lock_fail3");
        set_codes(1, 2, 3, 4, 1, 2, 3, 4);
        run_attempt("after_lock_pass");
    endtask

    task automatic test_abort();
        bit seen;
        bit launched;
        set_codes(7, 2, 3, 4, 1, 2, 3, 4);
        run_attempt("pre_abort_fail");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            if (idx === IDX_W'(2)) break;
            @(negedge clk);
        end
        checks++;
        if (idx !== IDX_W'(2) || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach_idx2: idx=%0d busy=%b", idx, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || idx !== '0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b idx=%0d, want 0 0", busy, idx);
        end
        seen = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            if (analysis_done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_done: analysis_done=1 seen, want none");
        end
        checks++;
        if (tries_left !== TRY_W'(tries_m) || match !== match_m) begin
            errors++;
            $display("FAIL abort_state: tries=%0d match=%b, want %0d %b", tries_left, match,
                     tries_m, match_m);
        end
        start = 1'b1;
        abort = 1'b1;
        launched = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) launched = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (launched) begin
            errors++;
            $display("FAIL start_abort_idle: busy=1 seen, want no launch");
        end
        set_codes(1, 2, 3, 4, 1, 2, 3, 4);
        run_attempt("post_abort_pass");
    endtask

    task automatic test_back_to_back();
        int t;
        int first;
        int second;
        set_codes(5, 6, 7, 8, 5, 6, 7, 8);
        @(negedge clk);
        start = 1'b1;
        first = -1;
        second = -1;
        t = 0;
        while (t < 4 * N + 20 && second < 0) begin
            @(negedge clk);
            t++;
            if (analysis_done === 1'b1) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        start = 1'b0;
        match_m = 1'b1;
        tries_m = MT;
        checks++;
        if (first < 0 || second - first != N + 2) begin
            errors++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, want gap %0d", first, second,
                     N + 2);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || match !== match_m || tries_left !== TRY_W'(tries_m)) begin
            errors++;
            $display("FAIL b2b_end: busy=%b match=%b tries=%0d", busy, match, tries_left);
        end
    endtask

    task automatic test_async_reset();
        set_codes(1, 2, 3, 0, 1, 2, 3, 4);
        run_attempt("pre_reset_fail");
        set_codes(1, 2, 3, 4, 1, 2, 3, 4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (idx !== '0 || busy !== 1'b0 || analysis_done !== 1'b0 || match !== 1'b0 ||
            locked !== 1'b0 || tries_left !== TRY_W'(MT)) begin
            errors++;
            $display("FAIL async_reset: idx=%0d busy=%b done=%b match=%b locked=%b tries=%0d",
                     idx, busy, analysis_done, match, locked, tries_left);
        end
        @(negedge clk);
        rst = 1'b1;
        tries_m = MT;
        match_m = 1'b0;
        run_attempt("post_reset_pass");
    endtask

    task automatic test_random();
        int k;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                rm[i] = DW'($urandom_range(0, (1 << DW) - 1));
                em[i] = rm[i];
            end
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, N - 1);
                em[k] = rm[k] ^ DW'($urandom_range(1, (1 << DW) - 1));
            end
            run_attempt("random");
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_lockout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
